axi_write_master: RTL and testbench

Parametrised AXI4 write-channel master engine, the next generation of the write-channel FSM model used in the verification wrapper. It accepts burst commands on a valid/ready command port and checks AXI4 legality. It drives the AW channel from a registered slot and streams user write data onto W with self-generated `axi_wlast`. It tracks up to `OUTSTANDING` in-flight bursts and returns B responses through a registered response port with sticky error status.

---
 rtl/axi_write_master.sv | 208 ++++++++++++++++++++
 tb/tb_axi_write_master.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_master.sv
`timescale 1ns/1ps
// AXI4 write-channel master: legality-checked command intake, registered AW slot,
// pass-through W with self-generated wlast, registered B response with sticky error.
module axi_write_master #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 64,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [AW-1:0]                    cmd_addr,
  input  logic [7:0]                       cmd_len,
  input  logic [2:0]                       cmd_size,
  input  logic [1:0]                       cmd_burst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [DW-1:0]                    wdata_in,
  input  logic [DW/8-1:0]                  wstrb_in,
  input  logic                             wvalid_in,
  output logic                             wready_out,
  output logic [AW-1:0]                    axi_awaddr,
  output logic [7:0]                       axi_awlen,
  output logic [2:0]                       axi_awsize,
  output logic [1:0]                       axi_awburst,
  output logic                             axi_awvalid,
  input  logic                             axi_awready,
  output logic [DW-1:0]                    axi_wdata,
  output logic [DW/8-1:0]                  axi_wstrb,
  output logic                             axi_wlast,
  output logic                             axi_wvalid,
  input  logic                             axi_wready,
  input  logic [1:0]                       axi_bresp,
  input  logic                             axi_bvalid,
  output logic                             axi_bready,
  output logic [1:0]                       resp_code,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic                             err_illegal,
  output logic                             err_sticky,
  output logic [$clog2(OUTSTANDING+1)-1:0] pending
);

  localparam int unsigned MaxSize = $clog2(DW / 8);
  localparam int unsigned PW      = $clog2(OUTSTANDING + 1);
  localparam int unsigned PtrW    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [7:0]    awlen_q, awlen_d;
  logic [2:0]    awsize_q, awsize_d;
  logic [1:0]    awburst_q, awburst_d;
  logic          awvalid_q, awvalid_d;
  logic          err_illegal_q, err_illegal_d;
  logic          err_sticky_q, err_sticky_d;
  logic [1:0]    resp_code_q, resp_code_d;
  logic          resp_valid_q, resp_valid_d;
  logic [PW-1:0] pending_q, pending_d;
  logic [PW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    beat_q, beat_d;
  logic [7:0]    fifo_mem_q [OUTSTANDING];

  logic        cmd_legal, cmd_fire, push, pop, w_fire, b_fire, orphan, b_take;
  logic        fifo_empty, misaligned;
  logic [7:0]  head_len;
  logic [16:0] incr_bytes, incr_end;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (32'(p) == OUTSTANDING - 1) return '0;
    return p + 1'b1;
  endfunction

  // Legality: 17-bit sum so a 4KB crossing is never hidden by truncation.
  always_comb begin
    incr_bytes = ({9'd0, cmd_len} + 17'd1) << cmd_size;
    incr_end   = {5'd0, cmd_addr[11:0]} + incr_bytes;
    misaligned = (cmd_addr[6:0] & ~(7'h7f << cmd_size)) != 7'd0;
    cmd_legal  = 1'b1;
    unique case (cmd_burst)
      2'b00:   if (cmd_len > 8'd15) cmd_legal = 1'b0;
      2'b01:   if (incr_end > 17'd4096) cmd_legal = 1'b0;
      2'b10: begin
        if (!(cmd_len == 8'd1 || cmd_len == 8'd3 || cmd_len == 8'd7 || cmd_len == 8'd15)) begin
          cmd_legal = 1'b0;
        end
        if (misaligned) cmd_legal = 1'b0;
      end
      default: cmd_legal = 1'b0;
    endcase
    if (32'(cmd_size) > MaxSize) cmd_legal = 1'b0;
  end

  assign cmd_ready  = !reset && (!awvalid_q || axi_awready) && (32'(pending_q) < OUTSTANDING);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign push       = cmd_fire && cmd_legal;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign head_len   = fifo_mem_q[rd_ptr_q];
  assign axi_wvalid = wvalid_in && !fifo_empty;
  assign wready_out = axi_wready && !fifo_empty;
  assign axi_wdata  = wdata_in;
  assign axi_wstrb  = wstrb_in;
  assign axi_wlast  = !fifo_empty && (beat_q == head_len);
  assign w_fire     = axi_wvalid && axi_wready;
  assign pop        = w_fire && axi_wlast;

  assign axi_bready = !reset && (!resp_valid_q || resp_ready);
  assign b_fire     = axi_bvalid && axi_bready;
  assign orphan     = b_fire && (pending_q == '0);
  assign b_take     = b_fire && !orphan;

  always_comb begin
    awaddr_d      = awaddr_q;
    awlen_d       = awlen_q;
    awsize_d      = awsize_q;
    awburst_d     = awburst_q;
    awvalid_d     = awvalid_q;
    resp_code_d   = resp_code_q;
    resp_valid_d  = resp_valid_q;
    pending_d     = pending_q;
    fifo_cnt_d    = fifo_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    beat_d        = beat_q;
    err_illegal_d = cmd_fire && !cmd_legal;
    err_sticky_d  = err_sticky_q || (b_fire && (axi_bresp[1] || orphan));

    if (push) begin
      awaddr_d  = cmd_addr;
      awlen_d   = cmd_len;
      awsize_d  = cmd_size;
      awburst_d = cmd_burst;
      awvalid_d = 1'b1;
      wr_ptr_d  = ptr_inc(wr_ptr_q);
    end else if (axi_awready) begin
      awvalid_d = 1'b0;
    end

    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (w_fire) beat_d = axi_wlast ? 8'd0 : beat_q + 8'd1;

    if (b_take) begin
      resp_code_d  = axi_bresp;
      resp_valid_d = 1'b1;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end

    unique case ({push, b_take})
      2'b10:   pending_d = pending_q + 1'b1;
      2'b01:   pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      awaddr_q      <= '0;
      awlen_q       <= '0;
      awsize_q      <= '0;
      awburst_q     <= '0;
      awvalid_q     <= 1'b0;
      err_illegal_q <= 1'b0;
      err_sticky_q  <= 1'b0;
      resp_code_q   <= '0;
      resp_valid_q  <= 1'b0;
      pending_q     <= '0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      beat_q        <= '0;
      for (int i = 0; i < OUTSTANDING; i++) fifo_mem_q[i] <= '0;
    end else begin
      awaddr_q      <= awaddr_d;
      awlen_q       <= awlen_d;
      awsize_q      <= awsize_d;
      awburst_q     <= awburst_d;
      awvalid_q     <= awvalid_d;
      err_illegal_q <= err_illegal_d;
      err_sticky_q  <= err_sticky_d;
      resp_code_q   <= resp_code_d;
      resp_valid_q  <= resp_valid_d;
      pending_q     <= pending_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      beat_q        <= beat_d;
      if (push) fifo_mem_q[wr_ptr_q] <= cmd_len;
    end
  end

  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awsize  = awsize_q;
  assign axi_awburst = awburst_q;
  assign axi_awvalid = awvalid_q;
  assign err_illegal = err_illegal_q;
  assign err_sticky  = err_sticky_q;
  assign resp_code   = resp_code_q;
  assign resp_valid  = resp_valid_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_axi_write_master.sv
`timescale 1ns/1ps
// Scenario bench for axi_write_master: directed cases plus randomized commands checked
// against an arithmetic legality model and per-burst beat/pending bookkeeping.
module tb_axi_write_master;

  logic        clk, reset;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        cmd_valid, cmd_ready;
  logic [63:0] wdata_in;
  logic [7:0]  wstrb_in;
  logic        wvalid_in, wready_out;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid, axi_awready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  resp_code;
  logic        resp_valid, resp_ready;
  logic        err_illegal, err_sticky;
  logic [2:0]  pending;

  int total = 0;
  int bad = 0;
  int pending_m = 0;
  bit sticky_m = 0;

  axi_write_master #(.AW(32), .DW(64), .OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wvalid_in(wvalid_in), .wready_out(wready_out),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .resp_code(resp_code), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .err_illegal(err_illegal), .err_sticky(err_sticky), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // AXI4 burst legality from the protocol rules, in plain arithmetic.
  function automatic bit legal_ref(input logic [31:0] a, input int unsigned len,
                                   input int unsigned size, input int unsigned burst);
    int unsigned bytes, off;
    bytes = 32'd1 << size;
    off   = 32'(a[11:0]);
    if (burst == 3 || bytes > 8) return 1'b0;
    if (burst == 2) return (len == 1 || len == 3 || len == 7 || len == 15) && (a % bytes == 0);
    if (burst == 0) return len <= 15;
    return off + (len + 1) * bytes <= 4096;
  endfunction

  task automatic drive_idle();
    cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
    wvalid_in = 0; wdata_in = 0; wstrb_in = 0; axi_awready = 1; axi_wready = 1;
    axi_bvalid = 0; axi_bresp = 0; resp_ready = 1;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1;
    @(negedge clk); @(negedge clk);
    reset = 0;
    pending_m = 0; sticky_m = 0;
  endtask

  task automatic gen_cmd();
    int unsigned sz, ln, bu;
    logic [31:0] a;
    bu = $urandom_range(0, 3);
    sz = $urandom_range(0, 4);
    ln = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
    a  = $urandom;
    if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 32'd1);
    if ($urandom_range(0, 2) == 0) a[11:0] = 12'(4096 - $urandom_range(1, 64));
    cmd_addr = a; cmd_len = ln[7:0]; cmd_size = sz[2:0]; cmd_burst = bu[1:0];
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1; wvalid_in = 1;
    @(negedge clk); @(negedge clk);
    #1;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    total++; if ({axi_awvalid, axi_wvalid, axi_wlast, wready_out, axi_bready} !== 5'b0) begin
      bad++; $display("FAIL reset_axi_ctrl got=%b exp=00000",
                      {axi_awvalid, axi_wvalid, axi_wlast, wready_out, axi_bready}); end
    total++; if ({resp_valid, resp_code, err_illegal, err_sticky, pending} !== 8'b0) begin
      bad++; $display("FAIL reset_status got=%b exp=0",
                      {resp_valid, resp_code, err_illegal, err_sticky, pending}); end
    total++; if ({axi_awaddr, axi_awlen, axi_awsize, axi_awburst} !== 45'b0) begin
      bad++; $display("FAIL reset_aw_payload got=%h exp=0", axi_awaddr); end
    reset = 0; wvalid_in = 0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL post_reset_cmd_ready got=%b exp=1", cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic_incr();
    cmd_addr = 32'h1000; cmd_len = 3; cmd_size = 3; cmd_burst = 2'b01; cmd_valid = 1;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL basic_cmd_ready got=%b exp=1", cmd_ready); end
    @(negedge clk); cmd_valid = 0;
    #1;
    total++; if (axi_awvalid !== 1'b1 || {axi_awaddr, axi_awlen, axi_awsize, axi_awburst} !==
                 {32'h1000, 8'd3, 3'd3, 2'b01}) begin
      bad++; $display("FAIL basic_aw got=%b/%h/%0d/%0d/%b exp=1/1000/3/3/01", axi_awvalid,
                      axi_awaddr, axi_awlen, axi_awsize, axi_awburst); end
    total++; if (pending !== 3'd1) begin bad++; $display("FAIL basic_pending got=%0d exp=1", pending); end
    wvalid_in = 1; axi_wready = 1;
    for (int b = 0; b < 4; b++) begin
      wdata_in = {$urandom, $urandom}; wstrb_in = 8'($urandom);
      #1;
      total++; if (axi_wlast !== (b == 3) || axi_wvalid !== 1'b1 || axi_wdata !== wdata_in) begin
        bad++; $display("FAIL basic_beat%0d got wlast=%b wvalid=%b exp wlast=%b wvalid=1", b,
                        axi_wlast, axi_wvalid, b == 3); end
      @(negedge clk);
    end
    wvalid_in = 0; axi_bvalid = 1; axi_bresp = 2'b00;
    #1;
    total++; if (axi_bready !== 1'b1) begin bad++; $display("FAIL basic_bready got=%b exp=1", axi_bready); end
    @(negedge clk); axi_bvalid = 0;
    #1;
    total++; if (resp_valid !== 1'b1 || resp_code !== 2'b00 || pending !== 3'd0) begin
      bad++; $display("FAIL basic_resp got=%b/%b/%0d exp=1/00/0", resp_valid, resp_code, pending); end
    @(negedge clk);
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL basic_resp_clear got=%b exp=0", resp_valid); end
  endtask

  task automatic test_illegal();
    logic [31:0] ta [3] = '{32'h100, 32'h0FF8, 32'h2000};
    logic [7:0]  tl [3] = '{8'd2, 8'd1, 8'd0};
    logic [2:0]  ts [3] = '{3'd2, 3'd3, 3'd4};
    logic [1:0]  tb [3] = '{2'b10, 2'b01, 2'b01};
    for (int i = 0; i < 3; i++) begin
      cmd_addr = ta[i]; cmd_len = tl[i]; cmd_size = ts[i]; cmd_burst = tb[i]; cmd_valid = 1;
      @(negedge clk); cmd_valid = 0;
      #1;
      total++; if (err_illegal !== 1'b1 || axi_awvalid !== 1'b0 || pending !== 3'd0) begin
        bad++; $display("FAIL illegal%0d got err=%b awvalid=%b pending=%0d exp 1/0/0", i,
                        err_illegal, axi_awvalid, pending); end
      @(negedge clk);
      #1;
      total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL illegal%0d_pulse got=%b exp=0", i, err_illegal); end
    end
  endtask

  task automatic test_random();
    int unsigned lens[$];
    int unsigned beat, guard;
    logic [1:0] br, prev_br;
    bit leg;
    prev_br = 0;
    for (int round = 0; round < 8; round++) begin
      lens.delete();
      for (int att = 0; att < 8 && lens.size() < 4; att++) begin
        gen_cmd();
        leg = legal_ref(cmd_addr, 32'(cmd_len), 32'(cmd_size), 32'(cmd_burst));
        cmd_valid = 1;
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rnd_cmd_ready got=%b exp=1", cmd_ready); end
        @(negedge clk); cmd_valid = 0;
        #1;
        total++; if (err_illegal !== !leg || axi_awvalid !== leg) begin
          bad++; $display("FAIL rnd_legality addr=%h len=%0d size=%0d burst=%0d got err=%b aw=%b exp err=%b aw=%b",
                          cmd_addr, cmd_len, cmd_size, cmd_burst, err_illegal, axi_awvalid, !leg, leg); end
        if (leg) begin
          lens.push_back(32'(cmd_len));
          pending_m++;
          total++; if ({axi_awaddr, axi_awlen, axi_awsize, axi_awburst} !==
                       {cmd_addr, cmd_len, cmd_size, cmd_burst}) begin
            bad++; $display("FAIL rnd_aw_payload got=%h/%0d exp=%h/%0d", axi_awaddr, axi_awlen,
                            cmd_addr, cmd_len); end
        end
        total++; if (pending !== 3'(pending_m)) begin bad++; $display("FAIL rnd_pending got=%0d exp=%0d", pending, pending_m); end
        @(negedge clk);
      end
      foreach (lens[k]) begin
        beat = 0; guard = 0;
        while (beat <= lens[k] && guard < 2000) begin
          wvalid_in = ($urandom_range(0, 3) != 0); axi_wready = ($urandom_range(0, 3) != 0);
          wdata_in = {$urandom, $urandom}; wstrb_in = 8'($urandom);
          #1;
          total++; if (axi_wlast !== (beat == lens[k])) begin
            bad++; $display("FAIL rnd_wlast burst=%0d beat=%0d len=%0d got=%b", k, beat, lens[k], axi_wlast); end
          total++; if (axi_wvalid !== wvalid_in || wready_out !== axi_wready ||
                       axi_wdata !== wdata_in || axi_wstrb !== wstrb_in) begin
            bad++; $display("FAIL rnd_wpass got wvalid=%b wready=%b exp wvalid=%b wready=%b",
                            axi_wvalid, wready_out, wvalid_in, axi_wready); end
          if (wvalid_in && axi_wready) beat++;
          guard++;
          @(negedge clk);
        end
        total++; if (guard >= 2000) begin bad++; $display("FAIL rnd_w_timeout burst=%0d beats=%0d exp=%0d", k, beat, lens[k] + 1); end
      end
      wvalid_in = 1; axi_wready = 1;
      #1;
      total++; if (axi_wvalid !== 1'b0 || wready_out !== 1'b0 || axi_wlast !== 1'b0) begin
        bad++; $display("FAIL rnd_empty_gate got=%b%b%b exp=000", axi_wvalid, wready_out, axi_wlast); end
      @(negedge clk); wvalid_in = 0;
      for (int i = 0; i < lens.size(); i++) begin
        br = 2'($urandom_range(0, 3));
        axi_bvalid = 1; axi_bresp = br; resp_ready = 1;
        #1;
        if (i > 0) begin
          total++; if (resp_valid !== 1'b1 || resp_code !== prev_br || pending !== 3'(pending_m)) begin
            bad++; $display("FAIL rnd_resp got=%b/%b/%0d exp=1/%b/%0d", resp_valid, resp_code,
                            pending, prev_br, pending_m); end
        end
        total++; if (axi_bready !== 1'b1) begin bad++; $display("FAIL rnd_bready got=%b exp=1", axi_bready); end
        @(negedge clk);
        pending_m--; if (br[1]) sticky_m = 1; prev_br = br;
      end
      axi_bvalid = 0;
      #1;
      if (lens.size() > 0) begin
        total++; if (resp_valid !== 1'b1 || resp_code !== prev_br) begin
          bad++; $display("FAIL rnd_last_resp got=%b/%b exp=1/%b", resp_valid, resp_code, prev_br); end
      end
      total++; if (pending !== 3'(pending_m) || err_sticky !== sticky_m) begin
        bad++; $display("FAIL rnd_end_state got pending=%0d sticky=%b exp %0d/%b", pending,
                        err_sticky, pending_m, sticky_m); end
      @(negedge clk);
    end
  endtask

  task automatic test_outstanding();
    cmd_addr = 32'h3000; cmd_len = 0; cmd_size = 2; cmd_burst = 2'b01; axi_awready = 1;
    cmd_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL out_accept%0d got=%b exp=1", i, cmd_ready); end
      @(negedge clk);
      cmd_addr = cmd_addr + 32'h10;
    end
    pending_m = 4;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (cmd_ready !== 1'b0 || pending !== 3'd4) begin
        bad++; $display("FAIL out_full got ready=%b pending=%0d exp 0/4", cmd_ready, pending); end
      @(negedge clk);
    end
    wvalid_in = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (axi_wlast !== 1'b1 || axi_wvalid !== 1'b1) begin
        bad++; $display("FAIL out_beat%0d got wlast=%b wvalid=%b exp 1/1", i, axi_wlast, axi_wvalid); end
      @(negedge clk);
    end
    wvalid_in = 0; axi_bvalid = 1; axi_bresp = 2'b00;
    @(negedge clk); axi_bvalid = 0;
    #1;
    total++; if (pending !== 3'd3 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL out_reopen got pending=%0d ready=%b exp 3/1", pending, cmd_ready); end
    @(negedge clk); cmd_valid = 0;
    #1;
    total++; if (pending !== 3'd4 || axi_awvalid !== 1'b1 || axi_awaddr !== 32'h3040) begin
      bad++; $display("FAIL out_fifth got pending=%0d aw=%b addr=%h exp 4/1/3040", pending,
                      axi_awvalid, axi_awaddr); end
    wvalid_in = 1;
    @(negedge clk); wvalid_in = 0;
    axi_bvalid = 1;
    repeat (4) @(negedge clk);
    axi_bvalid = 0;
    #1;
    total++; if (pending !== 3'd0 || resp_valid !== 1'b1) begin
      bad++; $display("FAIL out_drain got pending=%0d resp_valid=%b exp 0/1", pending, resp_valid); end
    pending_m = 0;
    @(negedge clk);
  endtask

  task automatic test_aw_stall();
    axi_awready = 0;
    cmd_addr = 32'h2000; cmd_len = 7; cmd_size = 3; cmd_burst = 2'b01; cmd_valid = 1;
    @(negedge clk); cmd_valid = 0;
    wvalid_in = 1; axi_wready = 1;
    for (int i = 0; i < 8; i++) begin
      wdata_in = {$urandom, $urandom};
      #1;
      total++; if (axi_awvalid !== 1'b1 || {axi_awaddr, axi_awlen, axi_awsize, axi_awburst} !==
                   {32'h2000, 8'd7, 3'd3, 2'b01} || cmd_ready !== 1'b0) begin
        bad++; $display("FAIL stall_aw%0d got aw=%b addr=%h len=%0d ready=%b exp 1/2000/7/0", i,
                        axi_awvalid, axi_awaddr, axi_awlen, cmd_ready); end
      total++; if (axi_wlast !== (i == 7) || axi_wvalid !== 1'b1) begin
        bad++; $display("FAIL stall_beat%0d got wlast=%b wvalid=%b exp %b/1", i, axi_wlast,
                        axi_wvalid, i == 7); end
      @(negedge clk);
    end
    wvalid_in = 0; axi_awready = 1;
    #1;
    total++; if (axi_awvalid !== 1'b1 || pending !== 3'd1) begin
      bad++; $display("FAIL stall_release got aw=%b pending=%0d exp 1/1", axi_awvalid, pending); end
    @(negedge clk);
    #1;
    total++; if (axi_awvalid !== 1'b0) begin bad++; $display("FAIL stall_aw_drop got=%b exp=0", axi_awvalid); end
    axi_bvalid = 1; axi_bresp = 2'b01;
    @(negedge clk); axi_bvalid = 0;
    #1;
    total++; if (resp_valid !== 1'b1 || resp_code !== 2'b01 || pending !== 3'd0) begin
      bad++; $display("FAIL stall_resp got=%b/%b/%0d exp 1/01/0", resp_valid, resp_code, pending); end
    @(negedge clk);
  endtask

  task automatic test_b_error();
    do_reset();
    cmd_addr = 32'h40; cmd_len = 0; cmd_size = 0; cmd_burst = 2'b00; cmd_valid = 1;
    @(negedge clk); cmd_valid = 0; wvalid_in = 1;
    @(negedge clk); wvalid_in = 0;
    axi_bvalid = 1; axi_bresp = 2'b10; resp_ready = 0;
    @(negedge clk); axi_bvalid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (resp_valid !== 1'b1 || resp_code !== 2'b10 || axi_bready !== 1'b0 ||
                   err_sticky !== 1'b1) begin
        bad++; $display("FAIL berr_hold%0d got valid=%b code=%b bready=%b sticky=%b exp 1/10/0/1",
                        i, resp_valid, resp_code, axi_bready, err_sticky); end
      @(negedge clk);
    end
    resp_ready = 1;
    #1;
    total++; if (axi_bready !== 1'b1) begin bad++; $display("FAIL berr_bready got=%b exp=1", axi_bready); end
    @(negedge clk);
    #1;
    total++; if (resp_valid !== 1'b0 || err_sticky !== 1'b1 || pending !== 3'd0) begin
      bad++; $display("FAIL berr_after got valid=%b sticky=%b pending=%0d exp 0/1/0", resp_valid,
                      err_sticky, pending); end
    do_reset();
    #1;
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL berr_reset_sticky got=%b exp=0", err_sticky); end
    axi_bvalid = 1; axi_bresp = 2'b00;
    @(negedge clk); axi_bvalid = 0;
    #1;
    total++; if (err_sticky !== 1'b1 || resp_valid !== 1'b0 || pending !== 3'd0) begin
      bad++; $display("FAIL orphan got sticky=%b valid=%b pending=%0d exp 1/0/0", err_sticky,
                      resp_valid, pending); end
    sticky_m = 1;
    @(negedge clk);
  endtask

  task automatic test_reset_midburst();
    axi_awready = 0;
    cmd_addr = 32'h5000; cmd_len = 3; cmd_size = 3; cmd_burst = 2'b01; cmd_valid = 1;
    @(negedge clk); cmd_valid = 0;
    wvalid_in = 1; axi_wready = 1;
    @(negedge clk); @(negedge clk);
    #1; reset = 1;
    #1;
    total++; if (axi_awvalid !== 1'b0 || resp_valid !== 1'b0 || pending !== 3'd0 ||
                 axi_wvalid !== 1'b0 || err_sticky !== 1'b0) begin
      bad++; $display("FAIL midreset got aw=%b rv=%b pending=%0d wvalid=%b sticky=%b exp all 0",
                      axi_awvalid, resp_valid, pending, axi_wvalid, err_sticky); end
    @(negedge clk);
    reset = 0; wvalid_in = 0; axi_awready = 1; pending_m = 0; sticky_m = 0;
    cmd_addr = 32'h6000; cmd_len = 1; cmd_size = 3; cmd_burst = 2'b01; cmd_valid = 1;
    @(negedge clk); cmd_valid = 0; wvalid_in = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (axi_wlast !== (i == 1) || pending !== 3'd1) begin
        bad++; $display("FAIL midreset_beat%0d got wlast=%b pending=%0d exp %b/1", i, axi_wlast,
                        pending, i == 1); end
      @(negedge clk);
    end
    wvalid_in = 0; axi_bvalid = 1; axi_bresp = 2'b00;
    @(negedge clk); axi_bvalid = 0;
    #1;
    total++; if (pending !== 3'd0 || resp_valid !== 1'b1) begin
      bad++; $display("FAIL midreset_resp got pending=%0d rv=%b exp 0/1", pending, resp_valid); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_incr();
    test_illegal();
    test_outstanding();
    test_aw_stall();
    test_random();
    test_b_error();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
